// File: rtl/riscv_pkg.sv
// Shared core types: datapath width plus the memory-arbiter state, owner and
// transaction-register layout.
package riscv_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_WAIT,
      ARB_RESP
   } arb_state_e;

   typedef enum logic {
      OWNER_IF,
      OWNER_D
   } arb_owner_e;

   typedef struct packed {
      arb_owner_e      owner;
      logic            we;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
   } arb_txn_t;

endpackage

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-ported unified memory: one transaction in
// flight, data first with a fetch starvation guard, stall and flush handling.
module mem_arbiter
   import riscv_pkg::*;
#(
   parameter int MAX_DATA_STREAK = 4,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            if_req_i,
   input  logic [XLEN-1:0] if_addr_i,
   output logic            if_gnt_o,
   output logic            if_rvalid_o,
   output logic [XLEN-1:0] if_rdata_o,
   input  logic            d_req_i,
   input  logic            d_we_i,
   input  logic [XLEN-1:0] d_addr_i,
   input  logic [XLEN-1:0] d_wdata_i,
   output logic            d_gnt_o,
   output logic            d_rvalid_o,
   output logic [XLEN-1:0] d_rdata_o,
   output logic            d_err_o,
   output logic            if_err_o,
   input  logic            if_flush_i,
   output logic            stall_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [XLEN-1:0] mem_wdata_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [XLEN-1:0] mem_rdata_i
);

   localparam int STRK_W = $clog2(MAX_DATA_STREAK + 1);
   localparam int TMO_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(MAX_DATA_STREAK);
   localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

   arb_state_e        state_q, state_d;
   arb_txn_t          txn_q, txn_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              drop_q, drop_d;
   logic [STRK_W-1:0] streak_q, streak_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;

   logic              fetch_wins;
   logic              grant_if;
   logic              grant_d;
   logic              busy_d_owner;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ARB_IDLE;
         txn_q    <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         drop_q   <= 1'b0;
         streak_q <= '0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         txn_q    <= txn_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         drop_q   <= drop_d;
         streak_q <= streak_d;
         tmo_q    <= tmo_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      txn_d      = txn_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      drop_d     = drop_q;
      streak_d   = streak_q;
      tmo_d      = tmo_q;
      // Data normally wins; a saturated streak hands the slot to a waiting fetch.
      fetch_wins = if_req_i && (!d_req_i || (streak_q == STRK_MAX));
      grant_if   = (state_q == ARB_IDLE) && fetch_wins;
      grant_d    = (state_q == ARB_IDLE) && d_req_i && !fetch_wins;

      unique case (state_q)
         ARB_IDLE: begin
            drop_d = 1'b0;
            if (grant_if) begin
               txn_d    = '{owner: OWNER_IF, we: 1'b0, addr: if_addr_i, wdata: '0};
               streak_d = '0;
               drop_d   = if_flush_i;
               state_d  = ARB_ISSUE;
            end else if (grant_d) begin
               txn_d   = '{owner: OWNER_D, we: d_we_i, addr: d_addr_i, wdata: d_wdata_i};
               state_d = ARB_ISSUE;
               if (!if_req_i) begin
                  streak_d = '0;
               end else if (streak_q != STRK_MAX) begin
                  streak_d = streak_q + STRK_W'(1);
               end
            end else begin
               streak_d = '0;
            end
         end
         ARB_ISSUE: begin
            if (mem_gnt_i) begin
               tmo_d   = TMO_W'(1);
               state_d = ARB_WAIT;
            end
         end
         ARB_WAIT: begin
            if (TIMEOUT_CYCLES != 0) begin
               tmo_d = tmo_q + TMO_W'(1);
            end
            if (mem_rvalid_i) begin
               rdata_d = txn_q.we ? '0 : mem_rdata_i;
               err_d   = 1'b0;
               state_d = ARB_RESP;
            end else if ((TIMEOUT_CYCLES != 0) && (tmo_q == TMO_MAX)) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = ARB_RESP;
            end
         end
         ARB_RESP: begin
            tmo_d   = '0;
            state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase

      // A redirect anywhere from the fetch grant through RESP poisons its response.
      if ((state_q != ARB_IDLE) && (txn_q.owner == OWNER_IF) && if_flush_i) begin
         drop_d = 1'b1;
      end
   end

   assign busy_d_owner = (state_q != ARB_IDLE) && (txn_q.owner == OWNER_D);

   // Grants and stall are combinational on the requests, so reset masks them.
   assign if_gnt_o    = grant_if && !rst_i;
   assign d_gnt_o     = grant_d && !rst_i;
   assign stall_o     = !rst_i && (d_req_i || busy_d_owner);

   assign if_rvalid_o = (state_q == ARB_RESP) && (txn_q.owner == OWNER_IF) &&
                        !drop_q && !if_flush_i;
   assign d_rvalid_o  = (state_q == ARB_RESP) && (txn_q.owner == OWNER_D);
   assign if_rdata_o  = if_rvalid_o ? rdata_q : '0;
   assign d_rdata_o   = d_rvalid_o ? rdata_q : '0;
   assign if_err_o    = if_rvalid_o && err_q;
   assign d_err_o     = d_rvalid_o && err_q;

   assign mem_req_o   = (state_q == ARB_ISSUE);
   assign mem_we_o    = mem_req_o && txn_q.we;
   assign mem_addr_o  = txn_q.addr;
   assign mem_wdata_o = txn_q.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a random
// traffic phase, all scored against a transaction-level reference model.
module tb_mem_arbiter;
   import riscv_pkg::*;

   localparam int MAXS = 4;
   localparam int TMO  = 8;
   localparam int QN   = 256;

   logic            clk = 1'b0;
   logic            rst_i = 1'b1;
   logic            if_req_i = 1'b0, d_req_i = 1'b0, d_we_i = 1'b0;
   logic [XLEN-1:0] if_addr_i = '0, d_addr_i = '0, d_wdata_i = '0;
   logic            if_flush_i = 1'b0;
   logic            mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
   logic [XLEN-1:0] mem_rdata_i = '0;
   logic            if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, d_err_o, if_err_o;
   logic            stall_o, mem_req_o, mem_we_o;
   logic [XLEN-1:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;

   mem_arbiter #(.MAX_DATA_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
      .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
      .d_err_o(d_err_o), .if_err_o(if_err_o), .if_flush_i(if_flush_i),
      .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Control written only by the main sequence.
   logic [31:0] if_addr_q [QN];
   logic        d_we_q    [QN];
   logic [31:0] d_addr_q  [QN];
   logic [31:0] d_wdata_q [QN];
   int  if_wr = 0, d_wr = 0;
   int  lat_max = 0;
   bit  mem_dead = 0, rand_flush = 0, rand_gap = 0, spurious = 0;
   int  flush_cyc = -1;

   // Environment state written only by the environment process.
   int  cyc = 0, if_rd = 0, d_rd = 0;
   bit  if_gnt_seen = 0, d_gnt_seen = 0;
   int  gnt_cnt = 0, rsp_cnt = 0;
   bit  m_busy = 0, m_we = 0;
   logic [31:0] m_addr = '0;
   logic [31:0] mem_arr [logic [31:0]];
   logic [31:0] ref_arr [logic [31:0]];
   int  n_mem_rsp = 0, n_if_gnt = 0, n_d_gnt = 0, n_if_rsp = 0, n_d_rsp = 0;
   int  if_gnt_cyc = 0, d_gnt_cyc = 0, if_rsp_cyc = 0, d_rsp_cyc = 0, stall_cnt = 0;
   logic [31:0] last_if_rdata = '0, last_d_rdata = '0;
   logic        last_d_err = 0, last_mem_we = 0;
   logic [31:0] last_mem_addr = '0, last_mem_wdata = '0;
   bit  ghist [1024];
   int  ghist_n = 0;
   bit  exp_vld = 0, exp_if = 0, exp_drop = 0, exp_err = 0;
   logic [31:0] exp_data = '0;
   int  streak_ref = 0;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      case (a)
         32'h0000_0100: return 32'h0050_0093;
         32'h0000_2000: return 32'hDEAD_BEEF;
         default:       return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
      endcase
   endfunction

   function automatic logic [31:0] rd_mem(input logic [31:0] a);
      return mem_arr.exists(a) ? mem_arr[a] : init_word(a);
   endfunction

   function automatic logic [31:0] rd_ref(input logic [31:0] a);
      return ref_arr.exists(a) ? ref_arr[a] : init_word(a);
   endfunction

   // Environment: drive memory and requesters after each rising edge, score at the falling edge.
   initial begin
      forever begin
         @(posedge clk); #1;
         cyc++;
         mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
         if (gnt_cnt > lat_max) gnt_cnt = lat_max;
         if (rst_i) begin
            m_busy = 0; gnt_cnt = 0;
         end else if (m_busy) begin
            if (rsp_cnt == 0) begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i  = m_we ? $urandom : rd_mem(m_addr);
               m_busy = 0; n_mem_rsp++;
            end else begin
               rsp_cnt--;
               if (spurious && $urandom_range(3, 0) == 0) mem_gnt_i = 1'b1;
            end
         end else if (mem_req_o && gnt_cnt == 0) begin
            mem_gnt_i = 1'b1;
            m_we = mem_we_o; m_addr = mem_addr_o;
            last_mem_we = mem_we_o; last_mem_addr = mem_addr_o; last_mem_wdata = mem_wdata_o;
            if (mem_we_o) mem_arr[mem_addr_o] = mem_wdata_o;
            m_busy  = !mem_dead;
            rsp_cnt = $urandom_range(lat_max, 0);
            gnt_cnt = $urandom_range(lat_max, 0);
         end else begin
            if (mem_req_o) gnt_cnt--;
            if (spurious && $urandom_range(3, 0) == 0) mem_rvalid_i = 1'b1;
         end

         if (rst_i) begin
            if_req_i = 1'b0; d_req_i = 1'b0; if_gnt_seen = 0; d_gnt_seen = 0;
         end else begin
            if (if_gnt_seen) begin if_req_i = 1'b0; if_gnt_seen = 0; end
            if (d_gnt_seen)  begin d_req_i  = 1'b0; d_gnt_seen  = 0; end
            if (!if_req_i && if_rd < if_wr && (!rand_gap || $urandom_range(3, 0) != 0)) begin
               if_req_i = 1'b1; if_addr_i = if_addr_q[if_rd % QN]; if_rd++;
            end
            if (!d_req_i && d_rd < d_wr && (!rand_gap || $urandom_range(3, 0) != 0)) begin
               d_req_i = 1'b1; d_we_i = d_we_q[d_rd % QN];
               d_addr_i = d_addr_q[d_rd % QN]; d_wdata_i = d_wdata_q[d_rd % QN]; d_rd++;
            end
         end
         if_flush_i = (cyc == flush_cyc) || (rand_flush && $urandom_range(7, 0) == 0);

         @(negedge clk);
         if (rst_i) begin
            chk("reset_outputs_zero", {31'b0, |{if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o,
                d_rvalid_o, d_rdata_o, d_err_o, if_err_o, stall_o, mem_req_o, mem_we_o,
                mem_addr_o, mem_wdata_o}}, 32'd0);
            exp_vld = 0;
         end else begin
            chk("gnt_onehot", {31'b0, if_gnt_o & d_gnt_o}, 32'd0);
            if (if_gnt_o || d_gnt_o) begin
               bit win_if;
               win_if = if_req_i && (!d_req_i || streak_ref == MAXS);
               chk("gnt_while_rsp_owed", {31'b0, exp_vld & ~exp_drop}, 32'd0);
               chk("winner_if", {31'b0, if_gnt_o}, {31'b0, win_if});
               chk("winner_d", {31'b0, d_gnt_o}, {31'b0, !win_if && d_req_i});
               exp_vld = 1; exp_drop = 0; exp_err = mem_dead;
               if (if_gnt_o) begin
                  exp_if = 1; exp_data = mem_dead ? 32'd0 : rd_ref(if_addr_i);
                  streak_ref = 0; if_gnt_seen = 1; n_if_gnt++; if_gnt_cyc = cyc;
                  ghist[ghist_n % 1024] = 0;
               end else begin
                  exp_if = 0;
                  exp_data = (mem_dead || d_we_i) ? 32'd0 : rd_ref(d_addr_i);
                  if (d_we_i && !mem_dead) ref_arr[d_addr_i] = d_wdata_i;
                  streak_ref = if_req_i ? ((streak_ref < MAXS) ? streak_ref + 1 : MAXS) : 0;
                  d_gnt_seen = 1; n_d_gnt++; d_gnt_cyc = cyc;
                  ghist[ghist_n % 1024] = 1;
               end
               ghist_n++;
            end
            if (if_flush_i && exp_vld && exp_if) exp_drop = 1;
            if (stall_o) stall_cnt++;
            chk("stall", {31'b0, stall_o}, {31'b0, d_req_i | (exp_vld & ~exp_if)});
            chk("err_unqualified", {31'b0, (d_err_o & ~d_rvalid_o) | (if_err_o & ~if_rvalid_o)}, 32'd0);
            if (if_rvalid_o) begin
               chk("if_rsp_expected", {31'b0, exp_vld & exp_if & ~exp_drop}, 32'd1);
               chk("if_rdata", if_rdata_o, exp_data);
               chk("if_err", {31'b0, if_err_o}, {31'b0, exp_err});
               last_if_rdata = if_rdata_o; if_rsp_cyc = cyc; n_if_rsp++; exp_vld = 0;
            end
            if (d_rvalid_o) begin
               chk("d_rsp_expected", {31'b0, exp_vld & ~exp_if}, 32'd1);
               chk("d_rdata", d_rdata_o, exp_data);
               chk("d_err", {31'b0, d_err_o}, {31'b0, exp_err});
               last_d_rdata = d_rdata_o; last_d_err = d_err_o; d_rsp_cyc = cyc;
               n_d_rsp++; exp_vld = 0;
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk); #2;
   endtask

   task automatic push_if(input logic [31:0] a);
      if_addr_q[if_wr % QN] = a; if_wr++;
   endtask

   task automatic push_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
      d_we_q[d_wr % QN] = we; d_addr_q[d_wr % QN] = a; d_wdata_q[d_wr % QN] = wd; d_wr++;
   endtask

   initial begin
      int a0, b0, g0, s0, m0;
      logic [6:0] pat;

      // Reset state
      repeat (3) tick();
      chk("reset_state", {31'b0, |{if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, stall_o,
          mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if_rdata_o, d_rdata_o}}, 32'd0);
      rst_i = 1'b0;
      repeat (2) tick();

      // Lone fetch with zero-wait memory
      a0 = n_if_rsp; s0 = stall_cnt;
      push_if(32'h100);
      for (int k = 0; k < 40 && n_if_rsp == a0; k++) tick();
      chk("lone_fetch_rsp", n_if_rsp - a0, 1);
      chk("lone_fetch_latency", if_rsp_cyc - if_gnt_cyc, 3);
      chk("lone_fetch_data", last_if_rdata, 32'h0050_0093);
      chk("lone_fetch_no_stall", stall_cnt - s0, 0);
      repeat (2) tick();

      // Simultaneous fetch and load
      a0 = n_if_rsp; g0 = ghist_n;
      push_if(32'h104); push_d(1'b0, 32'h2000, 32'h0);
      for (int k = 0; k < 40 && n_if_rsp == a0; k++) tick();
      chk("simul_fetch_rsp", n_if_rsp - a0, 1);
      chk("simul_first_is_d", {31'b0, ghist[g0 % 1024]}, 32'd1);
      chk("simul_then_fetch", {31'b0, ghist[(g0 + 1) % 1024]}, 32'd0);
      chk("simul_load_data", last_d_rdata, 32'hDEAD_BEEF);
      chk("simul_fetch_next_idle", if_gnt_cyc - d_gnt_cyc, 4);
      repeat (2) tick();

      // Starvation guard: 6 loads racing one fetch
      a0 = n_if_rsp; b0 = n_d_rsp; g0 = ghist_n;
      push_if(32'h108);
      for (int i = 0; i < 6; i++) push_d(1'b0, 32'h3000 + 32'(4 * i), 32'h0);
      for (int k = 0; k < 100 && (n_d_rsp - b0 < 6 || n_if_rsp == a0); k++) tick();
      chk("starve_all_done", {16'(n_d_rsp - b0), 16'(n_if_rsp - a0)}, {16'd6, 16'd1});
      for (int i = 0; i < 7; i++) pat[6 - i] = ghist[(g0 + i) % 1024];
      chk("starve_pattern", {25'b0, pat}, 32'h7B);
      repeat (2) tick();

      // Store then read back
      b0 = n_d_rsp; s0 = stall_cnt;
      push_d(1'b1, 32'h2004, 32'h1234_5678);
      for (int k = 0; k < 40 && n_d_rsp == b0; k++) tick();
      chk("store_rsp", n_d_rsp - b0, 1);
      chk("store_mem_we", {31'b0, last_mem_we}, 32'd1);
      chk("store_mem_addr", last_mem_addr, 32'h2004);
      chk("store_mem_wdata", last_mem_wdata, 32'h1234_5678);
      chk("store_rdata_zero", last_d_rdata, 32'h0);
      chk("store_stall_cycles", stall_cnt - s0, 4);
      repeat (2) tick();
      b0 = n_d_rsp;
      push_d(1'b0, 32'h2004, 32'h0);
      for (int k = 0; k < 40 && n_d_rsp == b0; k++) tick();
      chk("store_readback", last_d_rdata, 32'h1234_5678);
      repeat (2) tick();

      // Flush during WAIT drops the fetch response but not the memory transaction
      a0 = n_if_rsp; g0 = n_if_gnt; m0 = n_mem_rsp;
      push_if(32'h10C);
      for (int k = 0; k < 40 && n_if_gnt == g0; k++) tick();
      chk("flush_fetch_granted", n_if_gnt - g0, 1);
      flush_cyc = if_gnt_cyc + 2;
      repeat (8) tick();
      chk("flush_suppressed", n_if_rsp - a0, 0);
      chk("flush_mem_completed", n_mem_rsp - m0, 1);
      push_if(32'h110);
      for (int k = 0; k < 40 && n_if_rsp == a0; k++) tick();
      chk("flush_next_fetch", n_if_rsp - a0, 1);
      chk("flush_next_data", last_if_rdata, init_word(32'h110));
      repeat (2) tick();

      // Random traffic against the reference model
      lat_max = 3; rand_flush = 1; rand_gap = 1; spurious = 1;
      for (int i = 0; i < 150; i++) begin
         logic [31:0] ra;
         ra = 32'h4000 + 32'(4 * $urandom_range(15, 0));
         if ($urandom_range(2, 0) == 0) push_if(ra);
         else push_d($urandom_range(1, 0) == 1, ra, $urandom);
         repeat ($urandom_range(3, 0)) tick();
      end
      for (int k = 0; k < 4000 && (if_rd < if_wr || d_rd < d_wr || if_req_i || d_req_i); k++) tick();
      repeat (12) tick();
      chk("random_drained", {31'b0, (if_rd < if_wr) || (d_rd < d_wr) || if_req_i || d_req_i}, 32'd0);
      lat_max = 0; rand_flush = 0; rand_gap = 0; spurious = 0;
      repeat (4) tick();

      // Timeout with a memory that never answers
      mem_dead = 1;
      b0 = n_d_rsp;
      push_d(1'b0, 32'h2008, 32'h0);
      for (int k = 0; k < 60 && n_d_rsp == b0; k++) tick();
      chk("timeout_rsp", n_d_rsp - b0, 1);
      chk("timeout_err", {31'b0, last_d_err}, 32'd1);
      chk("timeout_rdata", last_d_rdata, 32'h0);
      chk("timeout_latency", d_rsp_cyc - d_gnt_cyc, 3 + TMO - 1);
      repeat (2) tick();

      // Reset in WAIT aborts at once
      g0 = n_d_gnt;
      push_d(1'b0, 32'h200C, 32'h0);
      for (int k = 0; k < 40 && n_d_gnt == g0; k++) tick();
      chk("reset_test_granted", n_d_gnt - g0, 1);
      while (cyc < d_gnt_cyc + 3) tick();
      rst_i = 1'b1;
      #1;
      chk("reset_mid_wait", {31'b0, |{if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, d_err_o,
          stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, d_rdata_o}}, 32'd0);
      repeat (2) tick();
      rst_i = 1'b0; mem_dead = 0;
      tick();
      a0 = n_if_rsp;
      push_if(32'h114);
      for (int k = 0; k < 40 && n_if_rsp == a0; k++) tick();
      chk("post_reset_fetch", n_if_rsp - a0, 1);
      chk("post_reset_latency", if_rsp_cyc - if_gnt_cyc, 3);
      chk("post_reset_data", last_if_rdata, init_word(32'h114));
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no completion, required $finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores produced by execute). It sits between those stages and the memory macro and serialises accesses, one outstanding transaction at a time. Data accesses have priority, with a starvation guard for fetch. It raises a stall toward the pipeline while the data stage waits, and discards fetch responses made stale by a branch or jump redirect.

## Interface
Parameters:
- MAX_DATA_STREAK, 4: consecutive data grants allowed while fetch is pending before fetch is forced to win (≥1).
- TIMEOUT_CYCLES, 255: maximum WAIT cycles before an error response; 0 disables the timeout.

Ports (XLEN from riscv_pkg):
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- if_req_i  in  1  fetch read request; held until if_gnt_o.
- if_addr_i  in  XLEN  fetch word address.
- if_gnt_o  out  1  fetch request captured (1-cycle pulse).
- if_rvalid_o  out  1  fetch response valid (1-cycle pulse).
- if_rdata_o  out  XLEN  instruction word.
- d_req_i  in  1  data request; held until d_gnt_o.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  XLEN  data address.
- d_wdata_i  in  XLEN  store data.
- d_gnt_o  out  1  data request captured (1-cycle pulse).
- d_rvalid_o  out  1  data response valid; also pulses for stores.
- d_rdata_o  out  XLEN  load data; 0 for stores.
- d_err_o  out  1  qualifies d_rvalid_o; timeout occurred.
- if_err_o  out  1  qualifies if_rvalid_o; timeout occurred.
- if_flush_i  in  1  redirect; in-flight fetch response must be dropped.
- stall_o  out  1  data request pending or data transaction in flight.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  XLEN  memory address.
- mem_wdata_o  out  XLEN  memory write data.
- mem_gnt_i  in  1  memory accepted request.
- mem_rvalid_i  in  1  memory response (reads and writes).
- mem_rdata_i  in  XLEN  memory read data.

## Operation
- FSM states IDLE, ISSUE, WAIT, RESP.
- IDLE: if any request is present, select an owner, latch addr/we/wdata into the transaction register, pulse the owner's gnt (combinational from state and req), and go to ISSUE. With no request, stay in IDLE.
- Selection: data wins over fetch. Exception: fetch wins if fetch is pending and the streak counter equals MAX_DATA_STREAK.
- Streak counter behaviour:
  - +1 on a data grant while if_req_i is high.
  - Cleared on any fetch grant.
  - Cleared on an IDLE cycle with if_req_i low.
  - Saturates at MAX_DATA_STREAK.
- ISSUE: hold mem_req_o plus the registered addr/we/wdata until mem_gnt_i, then go to WAIT. The request is never retracted.
- WAIT: the timeout counter increments each cycle.
  - On mem_rvalid_i: capture rdata (0 for stores) and go to RESP.
  - If the counter reaches TIMEOUT_CYCLES (when nonzero): go to RESP with err set and rdata 0.
- RESP: pulse the owner's rvalid with rdata/err for one cycle, then go to IDLE.
- Flush, fetch owner: if if_flush_i is high in any cycle from the fetch grant through RESP, a sticky drop bit is set. In RESP, if_rvalid_o is suppressed; the memory transaction still completes. Data transactions are unaffected. Drop clears in IDLE.
- stall_o = d_req_i OR (owner == data AND state ≠ IDLE). The RESP cycle of a data transaction is stalled. Pipeline stages advance the cycle after d_rvalid_o.
- mem_rvalid_i outside WAIT is ignored. mem_gnt_i outside ISSUE is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, drop bit 0, transaction register 0.
- Reset mid-transaction: abort to IDLE immediately. The memory must be reset by the same rst_i.
- Best case, with zero-wait memory:
  - Cycle 0: req, gnt.
  - Cycle 1: mem_req_o, mem_gnt_i.
  - Cycle 2: mem_rvalid_i.
  - Cycle 3: rvalid_o.
  - Cycle 4: next grant possible.
- Throughput: one transaction per 4 cycles at best.
- Simultaneous if_req_i and d_req_i in IDLE: exactly one gnt pulses. The loser's req stays high and is granted at the next IDLE.
- Timeout fires in the WAIT cycle where the counter equals TIMEOUT_CYCLES; RESP follows next cycle.

## Structure
- riscv_pkg gains:
  - arb_state_e {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP}.
  - arb_owner_e {OWNER_IF, OWNER_D}.
- Single module. The counters and FSM are small, so no sub-module is warranted.
- The streak counter is $clog2(MAX_DATA_STREAK+1) bits. The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits.

## Test plan
- Lone fetch: if_addr_i=0x100, memory answers rdata=0x00500093 one cycle after gnt → if_gnt_o at cycle 0, if_rvalid_o=1 with 0x00500093 at cycle 3, stall_o never high.
- Simultaneous requests: fetch 0x104 and load 0x2000 (mem 0xDEADBEEF) → data granted first, d_rdata_o=0xDEADBEEF; fetch granted at the next IDLE.
- Starvation: d_req_i held high for 6 transactions with if_req_i high, MAX_DATA_STREAK=4 → exactly 4 data grants, then 1 fetch grant, then data resumes.
- Store: d_we_i=1, addr 0x2004, wdata 0x12345678 → mem_we_o=1 with those values during ISSUE, d_rvalid_o=1 with d_rdata_o=0, stall_o high from request through RESP.
- Flush: if_flush_i pulsed in WAIT of a fetch → mem transaction completes, if_rvalid_o stays 0, next fetch response is delivered normally.
- Timeout and reset: TIMEOUT_CYCLES=8 with memory never responding → d_rvalid_o=1 and d_err_o=1 after 8 WAIT cycles. In a second run, rst_i asserted in WAIT → all outputs 0 the same cycle, FSM in IDLE.
